// File: rtl/serial_deframer.sv
// serial_deframer: collects a framed serial bit stream into M-bit words on a valid/ready output register.
// Optional odd-parity bit per frame is enabled by defining SERIAL_DEFRAMER_PARITY_EN.
module serial_deframer #(
    parameter int M         = 2,
    parameter bit MSB_FIRST = 1
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         d,
    input  logic         d_valid,
    input  logic         sof,
    output logic [M-1:0] q,
    output logic         q_valid,
    input  logic         q_ready,
    output logic         busy,
    output logic         frame_err,
    output logic         overflow,
    output logic         parity_err
);
    localparam int IW = (M > 2) ? $clog2(M) : 1;

`ifdef SERIAL_DEFRAMER_PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
    typedef enum logic {IDLE, SHIFT} state_t;
`endif

    state_t        state;
    logic          bits [0:M-1];
    logic [IW-1:0] count;
    logic [M-1:0]  word;
    logic          complete;

    assign busy = (state != IDLE);

    // Mapped word including the bit arriving this cycle, and the frame-complete strobe
    always_comb begin
        word = '0;
        for (int i = 0; i < M; i++)
            word[MSB_FIRST ? M-1-i : i] = (state == SHIFT && count == IW'(i)) ? d : bits[i];
`ifdef SERIAL_DEFRAMER_PARITY_EN
        complete = d_valid && !sof && state == PARITY;
`else
        complete = d_valid && !sof && state == SHIFT && count == IW'(M-1);
`endif
    end

`ifndef SERIAL_DEFRAMER_PARITY_EN
    assign parity_err = 1'b0;
`endif

    // Frame FSM, bit storage and output register with valid/ready handshake
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            count     <= '0;
            q         <= '0;
            q_valid   <= 1'b0;
            frame_err <= 1'b0;
            overflow  <= 1'b0;
`ifdef SERIAL_DEFRAMER_PARITY_EN
            parity_err <= 1'b0;
`endif
        end else begin
            frame_err <= d_valid && sof && state != IDLE;
            overflow  <= 1'b0;
            if (q_valid && q_ready)
                q_valid <= 1'b0;
            if (d_valid) begin
                if (sof) begin
                    bits[0] <= d;
                    count   <= IW'(1);
                    state   <= SHIFT;
                end else if (state == SHIFT) begin
                    bits[count] <= d;
                    count       <= count + IW'(1);
                    if (count == IW'(M-1))
`ifdef SERIAL_DEFRAMER_PARITY_EN
                        state <= PARITY;
                end else if (state == PARITY) begin
                    state <= IDLE;
`else
                        state <= IDLE;
`endif
                end
            end
            if (complete) begin
                if (!q_valid || q_ready) begin
                    q       <= word;
                    q_valid <= 1'b1;
`ifdef SERIAL_DEFRAMER_PARITY_EN
                    parity_err <= ~(^word ^ d);
`endif
                end else begin
                    overflow <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_serial_deframer.sv
// tb_serial_deframer: directed checks of serial_deframer (M=4) in MSB-first and LSB-first builds side by side.
module tb_serial_deframer;
    logic       clock = 1'b0;
    logic       reset, d, d_valid, sof, q_ready;
    logic [3:0] qm, ql;
    logic       qvm, qvl, bm, bl, fem, fel, ovm, ovl, pem, pel;
    int         errors = 0;
    int         checks = 0;

    always #5 clock = ~clock;

    serial_deframer #(.M(4), .MSB_FIRST(1)) u_msb (
        .clock(clock), .reset(reset), .d(d), .d_valid(d_valid), .sof(sof),
        .q(qm), .q_valid(qvm), .q_ready(q_ready), .busy(bm),
        .frame_err(fem), .overflow(ovm), .parity_err(pem)
    );

    serial_deframer #(.M(4), .MSB_FIRST(0)) u_lsb (
        .clock(clock), .reset(reset), .d(d), .d_valid(d_valid), .sof(sof),
        .q(ql), .q_valid(qvl), .q_ready(q_ready), .busy(bl),
        .frame_err(fel), .overflow(ovl), .parity_err(pel)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic bit_in(input logic b, input logic s);
        @(negedge clock);
        d = b;
        sof = s;
        d_valid = 1'b1;
    endtask

    task automatic idle();
        @(negedge clock);
        d_valid = 1'b0;
        sof = 1'b0;
    endtask

    // w[3] is the first bit on the wire; a correct odd-parity bit follows when parity is built in
    task automatic send_frame(input logic [3:0] w);
        for (int i = 0; i < 4; i++)
            bit_in(w[3-i], i == 0);
`ifdef SERIAL_DEFRAMER_PARITY_EN
        bit_in(~^w, 1'b0);
`endif
    endtask

    initial begin
        reset = 1'b1; d = 1'b0; d_valid = 1'b0; sof = 1'b0; q_ready = 1'b1;
        repeat (2) @(negedge clock);
        check("rst_q_msb", qm, 4'b0000);
        check("rst_q_lsb", ql, 4'b0000);
        check("rst_qvalid", {qvm, qvl}, 2'b00);
        check("rst_busy", {bm, bl}, 2'b00);
        check("rst_pulses", {fem, fel, ovm, ovl, pem, pel}, 6'b0);
        reset = 1'b0;

        send_frame(4'b1011);
        idle();
        check("f1_qvalid", {qvm, qvl}, 2'b11);
        check("f1_q_msb", qm, 4'b1011);
        check("f1_q_lsb", ql, 4'b1101);
        check("f1_busy", {bm, bl}, 2'b00);
        check("f1_parity", {pem, pel}, 2'b00);
        idle();
        check("f1_consumed", {qvm, qvl}, 2'b00);

        q_ready = 1'b0;
        send_frame(4'b1011);
        repeat (3) idle();
        check("hold_qvalid", {qvm, qvl}, 2'b11);
        check("hold_q_lsb", ql, 4'b1101);
        check("hold_q_msb", qm, 4'b1011);
        q_ready = 1'b1;
        idle();
        check("hold_release", {qvm, qvl}, 2'b00);

        bit_in(1'b1, 1'b1);
        idle();
        check("stall_busy", {bm, bl}, 2'b11);
        bit_in(1'b0, 1'b0);
        idle();
        idle();
        check("stall_novalid", {qvm, qvl}, 2'b00);
        bit_in(1'b1, 1'b0);
        bit_in(1'b1, 1'b0);
`ifdef SERIAL_DEFRAMER_PARITY_EN
        bit_in(1'b0, 1'b0);
`endif
        idle();
        check("stall_q_msb", qm, 4'b1011);
        check("stall_qvalid", {qvm, qvl}, 2'b11);
        check("stall_busy_end", {bm, bl}, 2'b00);
        idle();

        bit_in(1'b1, 1'b1);
        bit_in(1'b1, 1'b0);
        bit_in(1'b0, 1'b1);
        bit_in(1'b0, 1'b0);
        check("mid_ferr", {fem, fel}, 2'b11);
        check("mid_busy", {bm, bl}, 2'b11);
        bit_in(1'b1, 1'b0);
        check("mid_ferr_once", {fem, fel}, 2'b00);
        bit_in(1'b0, 1'b0);
`ifdef SERIAL_DEFRAMER_PARITY_EN
        bit_in(1'b0, 1'b0);
`endif
        idle();
        check("mid_q_msb", qm, 4'b0010);
        check("mid_q_lsb", ql, 4'b0100);
        check("mid_qvalid", {qvm, qvl}, 2'b11);
        idle();

        q_ready = 1'b0;
        send_frame(4'b1000);
        send_frame(4'b0111);
        idle();
        check("ovf_pulse", {ovm, ovl}, 2'b11);
        check("ovf_q_msb", qm, 4'b1000);
        check("ovf_q_lsb", ql, 4'b0001);
        check("ovf_qvalid", {qvm, qvl}, 2'b11);
        idle();
        check("ovf_once", {ovm, ovl}, 2'b00);
        q_ready = 1'b1;
        idle();

        send_frame(4'b1100);
        send_frame(4'b0011);
        q_ready = 1'b0;
        idle();
        check("b2b_q_msb", qm, 4'b0011);
        check("b2b_q_lsb", ql, 4'b1100);
        check("b2b_qvalid", {qvm, qvl}, 2'b11);
        check("b2b_noovf", {ovm, ovl}, 2'b00);

        bit_in(1'b1, 1'b1);
        bit_in(1'b0, 1'b0);
        @(negedge clock);
        reset = 1'b1;
        d_valid = 1'b0;
        sof = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        check("mrst_busy", {bm, bl}, 2'b00);
        check("mrst_qvalid", {qvm, qvl}, 2'b00);
        check("mrst_q", {qm, ql}, 8'h00);
        q_ready = 1'b1;
        send_frame(4'b0110);
        idle();
        check("mrst_q_msb", qm, 4'b0110);
        check("mrst_q_lsb", ql, 4'b0110);
        check("mrst_qvalid2", {qvm, qvl}, 2'b11);
        idle();

`ifdef SERIAL_DEFRAMER_PARITY_EN
        bit_in(1'b1, 1'b1);
        bit_in(1'b0, 1'b0);
        bit_in(1'b1, 1'b0);
        bit_in(1'b1, 1'b0);
        bit_in(1'b0, 1'b0);
        idle();
        check("par_good", {pem, pel}, 2'b00);
        check("par_good_q", qm, 4'b1011);
        bit_in(1'b1, 1'b1);
        bit_in(1'b0, 1'b0);
        bit_in(1'b1, 1'b0);
        bit_in(1'b1, 1'b0);
        bit_in(1'b1, 1'b0);
        idle();
        check("par_bad", {pem, pel}, 2'b11);
        check("par_bad_q", qm, 4'b1011);
        check("par_bad_qvalid", {qvm, qvl}, 2'b11);
`else
        check("par_tied", {pem, pel}, 2'b00);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/serial_deframer.md
# serial_deframer

- Receive-side counterpart of the team's parallel-to-serial frame transmitter.
- Collects a framed serial bit stream into an M-bit word and presents it on a valid/ready output register.
- Sits between a 1-bit link and word-wide consumer logic.
- Received bits are held in an unpacked array declared with a range, `[0:M-1]`; element i is the i-th received bit.

## Interface
Parameters:
- M, default 2: word width in bits; legal range M ≥ 2.
- MSB_FIRST, default 1: 1 = first received bit lands in q[M-1]; 0 = first received bit lands in q[0].

Ports:
- clock  in  1  single clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- d  in  1  serial data bit.
- d_valid  in  1  d is sampled this cycle.
- sof  in  1  start of frame; meaningful only when d_valid=1; marks the first bit of a frame.
- q  out  M  assembled word.
- q_valid  out  1  q holds an undelivered word.
- q_ready  in  1  consumer accepts q this cycle.
- busy  out  1  frame reception in progress (state ≠ IDLE).
- frame_err  out  1  one-cycle pulse when a sof arrives mid-frame.
- overflow  out  1  one-cycle pulse when a completed word is dropped.
- parity_err  out  1  parity mismatch for the word in q; qualified by q_valid.

## Operation
State machine: IDLE, SHIFT, PARITY (PARITY exists only with parity compiled in).

- **IDLE**
  - d_valid=1 with sof=0: bit ignored.
  - d_valid=1 with sof=1: store d in element 0, set bit count to 1, go to SHIFT.
- **SHIFT**
  - Each d_valid=1 with sof=0 stores d at element [count] and increments count.
  - Word completes when the M-th bit is stored:
    - parity disabled: go to IDLE.
    - parity enabled: go to PARITY.
  - d_valid=1 with sof=1: discard the partial word, pulse frame_err, and treat this bit as element 0 with count=1; stay in SHIFT.
- **PARITY**
  - The next d_valid=1 bit is the parity bit. Odd parity is required: XOR of the M data bits and the parity bit must equal 1.
  - Word completes; go to IDLE.
  - sof=1 on this bit is handled exactly as in SHIFT: frame_err pulse, restart with this bit as element 0.
- **Completion**
  - Word is loaded into q when the output register is free: q_valid=0, or q_valid=1 and q_ready=1 in the same cycle.
  - When loaded, q_valid=1.
  - Otherwise the word is dropped, q and q_valid are unchanged, and overflow pulses.
- **Output handshake**
  - q_valid && q_ready clears q_valid unless a new word loads in the same cycle, in which case q_valid stays 1.
  - q stays stable while q_valid=1 and q_ready=0.
- **Bit mapping**
  - MSB_FIRST=1: q[M-1-i] = element i.
  - MSB_FIRST=0: q[i] = element i.
- **Back-to-back frames**
  - A sof bit in the cycle directly after the completing bit is accepted (state is already IDLE).
  - Frames may arrive with no idle gap.
- **Reset (any time, including mid-frame)**
  - Partial word discarded, state IDLE.
  - q=0, q_valid=0, busy=0, frame_err=0, overflow=0, parity_err=0.

## Timing
- All outputs are registered.
- Latency: q_valid rises in the cycle after the clock edge that samples the completing bit (last data bit, or the parity bit when enabled).
- busy:
  - goes to 1 in the cycle after the sof bit;
  - returns to 0 in the cycle after the completing bit, unless a new sof bit arrives in that same cycle.
- frame_err and overflow are asserted for exactly one cycle, in the cycle after the triggering sample.
- Maximum throughput: one bit per clock; one word every M clocks, or M+1 with parity enabled.
- d_valid=0 cycles within a frame stall the count indefinitely; there is no timeout.

## Configuration
Macro `SERIAL_DEFRAMER_PARITY_EN`:
- **Defined:**
  - PARITY state present; frames are M+1 bits long.
  - parity_err is registered together with q: 1 when the XOR check equals 0.
  - A word with bad parity is still delivered.
- **Undefined:**
  - No PARITY state; frames are M bits long.
  - parity_err is tied to 0.
  - Port list is unchanged.

## Test plan
- M=4, MSB_FIRST=1, no parity: sof+bits 1,0,1,1 on consecutive cycles, q_ready=1 → q=4'b1011, q_valid high one cycle after the 4th bit, busy back to 0.
- M=4, MSB_FIRST=0: same bits → q=4'b1101; with q_ready held 0, q stays 4'b1101 until q_ready=1.
- Mid-frame sof: bits 1,1 then sof with bits 0,0,1,0 → frame_err pulses once, q=4'b0010.
- Overflow: q_ready=0, two complete frames back to back → first word held in q, overflow pulses one cycle after the second frame's last bit.
- Parity enabled, M=4: data 1,0,1,1 + parity 0 → parity_err=0; same data + parity 1 → parity_err=1 with q=4'b1011.
- reset asserted after 2 bits of a frame → next cycle busy=0, q_valid=0; following full frame 0,1,1,0 → q=4'b0110.
